// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 Hz timing constants, RGB565 colours and the no-pixel sentinel
//
// Shared by vga_ctrl and the pattern/image generators.
//   H_*/V_*          : default 640x480 timing, used as vga_ctrl parameter defaults
//   H_TOTAL/V_TOTAL  : line length in clocks / frame length in lines
//   RGB_*            : RGB565 colours common to all generators
//   PIX_NONE         : coordinate value meaning "no pixel requested"
package vga_pkg;

    localparam int H_SYNC  = 96;
    localparam int H_BACK  = 48;
    localparam int H_VALID = 640;
    localparam int H_FRONT = 16;
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;

    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 33;
    localparam int V_VALID = 480;
    localparam int V_FRONT = 10;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam logic [9:0] PIX_NONE = 10'h3ff;

    localparam logic [15:0] RGB_BLACK   = 16'h0000;
    localparam logic [15:0] RGB_WHITE   = 16'hffff;
    localparam logic [15:0] RGB_RED     = 16'hf800;
    localparam logic [15:0] RGB_GREEN   = 16'h07e0;
    localparam logic [15:0] RGB_BLUE    = 16'h001f;
    localparam logic [15:0] RGB_YELLOW  = 16'hffe0;
    localparam logic [15:0] RGB_CYAN    = 16'h07ff;
    localparam logic [15:0] RGB_MAGENTA = 16'hf81f;

    function automatic logic [15:0] rgb565(input logic [4:0] r, input logic [5:0] g,
                                           input logic [4:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/vga_ctrl.sv
// rtl/vga_ctrl.sv - VGA scan timing controller with one-clock-ahead pixel requests
//
// Ports:
//   clk          in   pixel clock (25 MHz for 640x480@60)
//   rst_n        in   asynchronous active-low reset
//   pix_data     in   RGB565 from a registered generator, valid one clk after pix_x/pix_y
//   pix_x/pix_y  out  requested column/row, PIX_NONE outside the request window
//   hsync/vsync  out  sync pulses, asserted level SYNC_POL
//   rgb_valid    out  display enable, high inside the active window
//   rgb          out  pix_data gated to zero outside the active window
//   frame_start  out  high while both counters are zero
module vga_ctrl #(
    parameter int   H_SYNC   = vga_pkg::H_SYNC,
    parameter int   H_BACK   = vga_pkg::H_BACK,
    parameter int   H_VALID  = vga_pkg::H_VALID,
    parameter int   H_FRONT  = vga_pkg::H_FRONT,
    parameter int   V_SYNC   = vga_pkg::V_SYNC,
    parameter int   V_BACK   = vga_pkg::V_BACK,
    parameter int   V_VALID  = vga_pkg::V_VALID,
    parameter int   V_FRONT  = vga_pkg::V_FRONT,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        rgb_valid,
    output logic [15:0] rgb,
    output logic        frame_start
);
    import vga_pkg::*;

    localparam int LINE_CLKS  = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int FRAME_LINES = V_SYNC + V_BACK + V_VALID + V_FRONT;

    if (LINE_CLKS > 1023 || FRAME_LINES > 1023) begin : g_param_check
        $error("vga_ctrl: timing parameter sums exceed the 10-bit counter range");
    end

    localparam logic [9:0] H_LAST     = 10'(LINE_CLKS - 1);
    localparam logic [9:0] V_LAST     = 10'(FRAME_LINES - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_BEG  = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_END  = 10'(H_SYNC + H_BACK + H_VALID);
    // Request window leads the display window by one clock to cover the generator register.
    localparam logic [9:0] H_REQ_BEG  = 10'(H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_REQ_END  = 10'(H_SYNC + H_BACK + H_VALID - 1);
    localparam logic [9:0] V_ACT_BEG  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_END  = 10'(V_SYNC + V_BACK + V_VALID);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       v_act;
    logic       pix_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign hsync = (h_cnt < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    assign vsync = (v_cnt < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;

    assign v_act     = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    assign rgb_valid = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END) && v_act;
    assign pix_req   = (h_cnt >= H_REQ_BEG) && (h_cnt < H_REQ_END) && v_act;

    assign pix_x = pix_req ? h_cnt - H_REQ_BEG : PIX_NONE;
    assign pix_y = pix_req ? v_cnt - V_ACT_BEG : PIX_NONE;

    assign rgb         = rgb_valid ? pix_data : 16'd0;
    assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);

endmodule

// File: tb/tb_vga_ctrl.sv
// tb/tb_vga_ctrl.sv - self-checking bench for vga_ctrl (reduced-timing and default-timing instances)
module tb_vga_ctrl;
    import vga_pkg::*;

    // Reduced timing keeps many whole frames inside a short run.
    localparam int S_HS = 3, S_HB = 2, S_HV = 8, S_HF = 2;
    localparam int S_VS = 2, S_VB = 2, S_VV = 4, S_VF = 2;
    localparam int S_HT = S_HS + S_HB + S_HV + S_HF;
    localparam int S_VT = S_VS + S_VB + S_VV + S_VF;
    localparam int S_HA = S_HS + S_HB;
    localparam int S_VA = S_VS + S_VB;
    localparam int B_LINES = 36;

    logic        clk = 1'b0;
    logic        rst_s, rst_b;
    logic [15:0] pd_s = 16'h0, pd_b = 16'h0;
    logic [9:0]  px_s, py_s, px_b, py_b;
    logic        hs_s, vs_s, dv_s, fs_s, hs_b, vs_b, dv_b, fs_b;
    logic [15:0] rgb_s, rgb_b;

    always #20 clk = ~clk;

    vga_ctrl #(
        .H_SYNC(S_HS), .H_BACK(S_HB), .H_VALID(S_HV), .H_FRONT(S_HF),
        .V_SYNC(S_VS), .V_BACK(S_VB), .V_VALID(S_VV), .V_FRONT(S_VF),
        .SYNC_POL(1'b0)
    ) dut_s (
        .clk(clk), .rst_n(rst_s), .pix_data(pd_s), .pix_x(px_s), .pix_y(py_s),
        .hsync(hs_s), .vsync(vs_s), .rgb_valid(dv_s), .rgb(rgb_s), .frame_start(fs_s)
    );

    vga_ctrl dut_b (
        .clk(clk), .rst_n(rst_b), .pix_data(pd_b), .pix_x(px_b), .pix_y(py_b),
        .hsync(hs_b), .vsync(vs_b), .rgb_valid(dv_b), .rgb(rgb_b), .frame_start(fs_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Registered generator; no-pixel coordinates return all-ones so any leak shows on rgb.
    function automatic logic [15:0] gen(input logic [9:0] x, input logic [9:0] y);
        if (x == PIX_NONE || y == PIX_NONE) return 16'hffff;
        return {x[4:0], x[5:0], y[4:0]};
    endfunction

    function automatic bit in_rng(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction

    always @(posedge clk) begin
        pd_s <= gen(px_s, py_s);
        pd_b <= gen(px_b, py_b);
    end

    // Reference model for the reduced-timing instance plus rgb scoreboard.
    int          mh = 0, mv = 0;
    logic [15:0] sb_q[$];
    int          frames = 0, since_fs = 0, vld_cnt = 0, period_checks = 0, post_rst_periods = 0;
    bit          have_prev = 1'b0, mid_rst = 1'b0;

    always @(negedge clk) begin
        int          nh, nv;
        bit          req, dv;
        logic [9:0]  ex, ey;
        logic [15:0] popped;
        if (!rst_s) begin
            mh = 0; mv = 0;
            sb_q.delete();
            have_prev = 1'b0;
            vld_cnt = 0;
        end
        req = in_rng(mh, S_HA - 1, S_HA + S_HV - 1) && in_rng(mv, S_VA, S_VA + S_VV);
        dv  = in_rng(mh, S_HA, S_HA + S_HV) && in_rng(mv, S_VA, S_VA + S_VV);
        ex  = req ? 10'(mh - (S_HA - 1)) : PIX_NONE;
        ey  = req ? 10'(mv - S_VA) : PIX_NONE;
        check_eq("s_hsync", {31'd0, hs_s}, (mh < S_HS) ? 32'd0 : 32'd1);
        check_eq("s_vsync", {31'd0, vs_s}, (mv < S_VS) ? 32'd0 : 32'd1);
        check_eq("s_rgb_valid", {31'd0, dv_s}, {31'd0, dv});
        check_eq("s_pix_x", {22'd0, px_s}, {22'd0, ex});
        check_eq("s_pix_y", {22'd0, py_s}, {22'd0, ey});
        check_eq("s_frame_start", {31'd0, fs_s}, (mh == 0 && mv == 0) ? 32'd1 : 32'd0);
        if (!rst_s) begin
            check_eq("s_rgb_in_reset", {16'd0, rgb_s}, 32'd0);
        end else if (sb_q.size() > 0) begin
            popped = sb_q.pop_front();
            check_eq("s_rgb", {16'd0, rgb_s}, {16'd0, popped});
        end
        if (rst_s) begin
            if (fs_s) begin
                if (have_prev) begin
                    check_eq("s_frame_period", since_fs, S_HT * S_VT);
                    check_eq("s_valid_per_frame", vld_cnt, S_HV * S_VV);
                    period_checks++;
                    if (mid_rst) post_rst_periods++;
                end
                have_prev = 1'b1;
                since_fs = 0;
                vld_cnt = 0;
                frames++;
            end
            since_fs++;
            if (dv_s) vld_cnt++;
            nh = (mh == S_HT - 1) ? 0 : mh + 1;
            nv = (mh == S_HT - 1) ? ((mv == S_VT - 1) ? 0 : mv + 1) : mv;
        end else begin
            nh = 0; nv = 0;
        end
        sb_q.push_back((in_rng(nh, S_HA, S_HA + S_HV) && in_rng(nv, S_VA, S_VA + S_VV))
                       ? gen(ex, ey) : 16'h0000);
        mh = nh; mv = nv;
    end

    // Spot checks on the default 640x480 instance over its first 36 lines.
    int big_k = 0;

    always @(negedge clk) begin
        int bh, bv;
        if (!rst_b) begin
            check_eq("b_rst_hsync", {31'd0, hs_b}, 32'd0);
            check_eq("b_rst_vsync", {31'd0, vs_b}, 32'd0);
            check_eq("b_rst_rgb", {16'd0, rgb_b}, 32'd0);
            check_eq("b_rst_pix_x", {22'd0, px_b}, 32'h3ff);
        end else if (big_k <= B_LINES * 800) begin
            bh = big_k % 800;
            bv = big_k / 800;
            if (bv == 0 && (bh == 0 || bh == 95)) check_eq("b_hsync_lo", {31'd0, hs_b}, 32'd0);
            if (bv == 0 && (bh == 96 || bh == 799)) check_eq("b_hsync_hi", {31'd0, hs_b}, 32'd1);
            if (bh == 0 && bv <= 2) check_eq("b_vsync", {31'd0, vs_b}, (bv < 2) ? 32'd0 : 32'd1);
            if (big_k == 0) check_eq("b_fs_first", {31'd0, fs_b}, 32'd1);
            if (big_k == 1 || big_k == 800) check_eq("b_fs_low", {31'd0, fs_b}, 32'd0);
            if (bv == 34 && bh == 143) check_eq("b_line34_pix_y", {22'd0, py_b}, 32'h3ff);
            if (bv == 35) begin
                case (bh)
                    142: check_eq("b_pix_x_142", {22'd0, px_b}, 32'h3ff);
                    143: begin
                        check_eq("b_pix_x_143", {22'd0, px_b}, 32'd0);
                        check_eq("b_pix_y_143", {22'd0, py_b}, 32'd0);
                        check_eq("b_valid_143", {31'd0, dv_b}, 32'd0);
                    end
                    144: check_eq("b_valid_144", {31'd0, dv_b}, 32'd1);
                    145: check_eq("b_rgb_145", {16'd0, rgb_b}, {16'd0, gen(10'd1, 10'd0)});
                    782: check_eq("b_pix_x_782", {22'd0, px_b}, 32'd639);
                    783: begin
                        check_eq("b_pix_x_783", {22'd0, px_b}, 32'h3ff);
                        check_eq("b_valid_783", {31'd0, dv_b}, 32'd1);
                    end
                    784: check_eq("b_valid_784", {31'd0, dv_b}, 32'd0);
                    default: ;
                endcase
            end
            big_k++;
        end
    end

    initial begin
        int guard;
        rst_s = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_s = 1'b1;
        rst_b = 1'b1;

        // Mid-frame reset inside the active window of the reduced instance.
        guard = 0;
        do begin
            @(posedge clk);
            #2;
            guard++;
        end while (!(frames >= 3 && mv == 6 && mh == 9) && guard < 5000);
        check_eq("s_rst_point_reached", (guard < 5000) ? 32'd1 : 32'd0, 32'd1);
        rst_s = 1'b0;
        mid_rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_s = 1'b1;

        for (int i = 0; i < 40000 && big_k <= B_LINES * 800; i++) @(posedge clk);
        check_eq("b_run_complete", (big_k > B_LINES * 800) ? 32'd1 : 32'd0, 32'd1);
        check_eq("s_periods_seen", (period_checks >= 10) ? 32'd1 : 32'd0, 32'd1);
        check_eq("s_period_after_rst", (post_rst_periods >= 1) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
